pcap_rec_fmt: RTL
=================

# pcap_rec_fmt

Downstream stage of the packet read controller: drains 32-bit packet words from the show-ahead capture FIFO and emits one pcap record per packet as an Avalon-ST source stream. Each record is a 4-word pcap record header (ts_sec, ts_usec, incl_len, orig_len) followed by the payload words. The block keeps its own free-running seconds/microseconds timestamp, which it latches when the packet starts.

## Interface
Parameters:
- CLK_FREQ_HZ, 50_000_000, clk frequency. Must be an integer multiple of 1_000_000.

Ports:
- clk  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-low reset
- pkt_start  in  1  one-cycle pulse announcing a packet whose words will arrive in the FIFO
- pkt_len  in  16  packet length in bytes; sampled with pkt_start
- fifo_out  in  32  FIFO head word (show-ahead; valid whenever !fifo_empty)
- fifo_empty  in  1  FIFO empty flag
- rd_from_fifo  out  1  pop strobe; head word consumed this cycle
- st_data  out  32  stream data
- st_valid  out  1  stream valid
- st_ready  in  1  sink ready (readyLatency 0)
- st_sop  out  1  first header word of a record
- st_eop  out  1  last word of a record
- st_empty  out  2  unused bytes in the eop word
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a record completes
- pkt_drop  out  1  one-cycle pulse when pkt_start is ignored

## Operation
- Timestamp: prescaler counts 0..CLK_FREQ_HZ/1e6-1. On each wrap, usec increments. usec counts 0..999_999, then wraps to 0 and sec increments. sec is 32 bits and wraps modulo 2^32. All three counters run continuously from reset.
- FSM states: IDLE, HDR, PAYLOAD.
  - IDLE: when pkt_start is seen, latch sec, usec and pkt_len, set hdr_idx=0 and words_left=ceil(pkt_len/4) (17-bit arithmetic, no overflow), and go to HDR.
  - HDR: emits header words in order: sec, usec, pkt_len (zero-extended), pkt_len. st_sop is set on word 0. After word 3 transfers, go to PAYLOAD if words_left≠0. Otherwise return to IDLE; in that case word 3 carries st_eop=1 and st_empty=0.
  - PAYLOAD: each pop loads fifo_out into the output register and decrements words_left. The last word carries st_eop=1 and st_empty=(4−pkt_len mod 4) mod 4. The eop transfer returns the FSM to IDLE.
- Output register update rule: the register may load only when (!st_valid || st_ready). While st_valid=1 and st_ready=0, st_data, st_sop, st_eop and st_empty hold stable.
- In PAYLOAD, rd_from_fifo = load_allowed && !fifo_empty && words_left≠0. It is combinational and never asserts while the FIFO is empty.
- done pulses in the cycle after the eop transfer.
- pkt_start while busy: ignored and pkt_drop pulses. The in-progress record is unaffected.
- Payload byte order: a FIFO word passes through unmodified.

## Timing
- Reset (asynchronous, takes effect immediately): FSM to IDLE. prescaler, usec, sec, words_left and hdr_idx go to 0. st_valid, st_sop, st_eop, rd_from_fifo, done, pkt_drop and busy go to 0. st_data=0, st_empty=0.
- Reset in the middle of a packet abandons the record with no eop. Words left in the FIFO belong to the upstream block, which is also reset.
- pkt_start in cycle N gives st_valid=1 with the sec word in cycle N+1.
- With st_ready held at 1 and the FIFO never empty, the record transfers in 4+ceil(pkt_len/4) consecutive cycles with no bubbles.
- A header-to-payload bubble occurs only if the FIFO is empty.
- The cycle after the eop transfer, the block is in IDLE and a new pkt_start is accepted.
- The timestamp latches the counter values present in the pkt_start cycle (pre-increment).
- Simultaneous pkt_start and eop transfer: the block is still busy in that cycle, so pkt_start is dropped.

## Test plan
- Reset to cycle 0 counters. Wait for usec=12, then pkt_start with pkt_len=8 and FIFO words 0xA0A1A2A3, 0xB0B1B2B3, st_ready=1. Expect 6 consecutive beats: 0, 12, 8, 8, 0xA0A1A2A3, 0xB0B1B2B3. sop on beat 1, eop on beat 6, st_empty=0, done pulses next cycle.
- pkt_len=5 with 2 FIFO words: expect eop on the second payload word with st_empty=3. pkt_len=0: expect 4 header beats, eop on the 4th, st_empty=0, rd_from_fifo never asserted.
- pkt_len=64 with st_ready toggling 1/0 every cycle and the FIFO emptying for 3 cycles mid-packet: expect exactly 20 transfers, data held stable while stalled, no pop while fifo_empty, correct word order.
- Second pkt_start during PAYLOAD: expect a pkt_drop pulse, the first record completes intact, and no second record.
- Assert reset during PAYLOAD of a pkt_len=32 packet: expect all outputs at reset values immediately, busy=0, and a new packet after reset formatted correctly.
- CLK_FREQ_HZ=2_000_000 with the counter preloaded via a long wait: at usec 999_999 to 0 rollover, sec increments by 1. A packet started in the rollover cycle carries the old (sec, 999_999).

Source files
------------

// File: rtl/pcap_rec_fmt.sv
// pcap_rec_fmt: drains packet words from a show-ahead FIFO and emits one pcap record
//   (ts_sec, ts_usec, incl_len, orig_len, payload...) per packet as an Avalon-ST source.
// Latency: pkt_start in cycle N presents the ts_sec word in cycle N+1; one word per cycle after that.
// Backpressure: the output register holds while st_valid && !st_ready; the FIFO is popped only when the register can load.
// Ports: clk/reset (async, active-low); pkt_start/pkt_len announce a packet; fifo_out/fifo_empty/rd_from_fifo
//   drain the capture FIFO; st_* is the record stream; busy/done/pkt_drop are status strobes.
module pcap_rec_fmt #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pkt_start,
    input  logic [15:0] pkt_len,
    input  logic [31:0] fifo_out,
    input  logic        fifo_empty,
    output logic        rd_from_fifo,
    output logic [31:0] st_data,
    output logic        st_valid,
    input  logic        st_ready,
    output logic        st_sop,
    output logic        st_eop,
    output logic [1:0]  st_empty,
    output logic        busy,
    output logic        done,
    output logic        pkt_drop
);
    localparam int unsigned DIV   = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    // free-running timestamp
    logic [PRE_W-1:0] prescaler;
    logic [19:0]      usec;
    logic [31:0]      sec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            usec      <= '0;
            sec       <= '0;
        end else if (prescaler == PRE_MAX) begin
            prescaler <= '0;
            if (usec == 20'd999_999) begin
                usec <= '0;
                sec  <= sec + 32'd1;
            end else begin
                usec <= usec + 20'd1;
            end
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    state_t      state, state_nxt;
    logic [1:0]  hdr_idx, hdr_idx_nxt;      // index of the header word held in the output register
    logic [16:0] words_left, words_left_nxt; // payload words not yet popped
    logic [19:0] ts_usec;
    logic [15:0] len_q;
    logic [31:0] data_nxt;
    logic        valid_nxt, sop_nxt, eop_nxt;
    logic [1:0]  empty_nxt;
    logic        latch, pop, drop;

    wire load_ok  = !st_valid || st_ready;
    wire xfer     = st_valid && st_ready;
    wire eop_xfer = xfer && st_eop;

    always_comb begin
        state_nxt      = state;
        hdr_idx_nxt    = hdr_idx;
        words_left_nxt = words_left;
        data_nxt       = st_data;
        valid_nxt      = st_valid;
        sop_nxt        = st_sop;
        eop_nxt        = st_eop;
        empty_nxt      = st_empty;
        latch          = 1'b0;
        pop            = 1'b0;
        drop           = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_start) begin
                    // the sec word is loaded right away so it is valid in the next cycle
                    latch          = 1'b1;
                    state_nxt      = HDR;
                    hdr_idx_nxt    = 2'd0;
                    words_left_nxt = (17'(pkt_len) + 17'd3) >> 2;
                    data_nxt       = sec;
                    valid_nxt      = 1'b1;
                    sop_nxt        = 1'b1;
                    eop_nxt        = 1'b0;
                    empty_nxt      = 2'd0;
                end
            end
            HDR: begin
                // st_valid is always set in HDR, so st_ready alone marks a transfer
                drop = pkt_start;
                if (st_ready) begin
                    sop_nxt = 1'b0;
                    if (hdr_idx != 2'd3) begin
                        hdr_idx_nxt = hdr_idx + 2'd1;
                        data_nxt    = (hdr_idx == 2'd0) ? 32'(ts_usec) : 32'(len_q);
                        eop_nxt     = (hdr_idx == 2'd2) && (words_left == 17'd0);
                    end else if (words_left == 17'd0) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        eop_nxt   = 1'b0;
                    end else begin
                        // pop alongside the last header transfer to avoid a bubble
                        state_nxt = PAYLOAD;
                        valid_nxt = 1'b0;
                        pop       = !fifo_empty;
                    end
                end
            end
            PAYLOAD: begin
                drop = pkt_start;
                pop  = load_ok && !fifo_empty && (words_left != 17'd0);
                if (!pop && xfer) begin
                    valid_nxt = 1'b0;
                    eop_nxt   = 1'b0;
                    if (st_eop) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (pop) begin
            data_nxt       = fifo_out;
            valid_nxt      = 1'b1;
            sop_nxt        = 1'b0;
            eop_nxt        = (words_left == 17'd1);
            empty_nxt      = (words_left == 17'd1) ? 2'(2'd0 - len_q[1:0]) : 2'd0;
            words_left_nxt = words_left - 17'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            hdr_idx    <= '0;
            words_left <= '0;
            ts_usec    <= '0;
            len_q      <= '0;
            st_data    <= '0;
            st_valid   <= 1'b0;
            st_sop     <= 1'b0;
            st_eop     <= 1'b0;
            st_empty   <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            hdr_idx    <= hdr_idx_nxt;
            words_left <= words_left_nxt;
            st_data    <= data_nxt;
            st_valid   <= valid_nxt;
            st_sop     <= sop_nxt;
            st_eop     <= eop_nxt;
            st_empty   <= empty_nxt;
            done       <= eop_xfer;
            if (latch) begin
                ts_usec <= usec;
                len_q   <= pkt_len;
            end
        end
    end

    assign rd_from_fifo = pop;
    assign pkt_drop     = drop;
    assign busy         = (state != IDLE);
endmodule
